// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// parity helper used by both directions of the link.
package uart_pkg;

   localparam int BAUD_DIVISOR_DEFAULT = 868;
   localparam int DATA_BITS            = 8;

   typedef enum logic {
      STOP_ONE = 1'b0,
      STOP_TWO = 1'b1
   } stop_bits_t;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_START      = 3'd1,
      ST_DATA       = 3'd2,
      ST_PARITY     = 3'd3,
      ST_STOP1      = 3'd4,
      ST_STOP2      = 3'd5,
      ST_BREAK_WAIT = 3'd6
   } uart_rx_state_t;

   // XOR reduction of a data byte; 1 when the byte has an odd number of ones.
   function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous level; the reset value is a
// parameter so an idle-high line stays idle through reset.
module uart_sync2 #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Metastability-settling pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= RESET_VALUE;
         sync_r <= RESET_VALUE;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit qualification, mid-bit sampling of 8 data bits,
// parity and one or two stop bits, with a one-entry valid/ready output buffer.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_DIVISOR = BAUD_DIVISOR_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_in,
   input  logic       odd_parity,
   input  logic       two_stop,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun_err
);

   localparam int CNT_W = $clog2(BAUD_DIVISOR);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIVISOR / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIVISOR - 1);
   localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

   logic                 rx_s;
   uart_rx_state_t       state_r, state_nxt;
   logic [CNT_W-1:0]     cnt_r;
   logic [2:0]           bit_cnt_r;
   logic [DATA_BITS-1:0] shift_r;
   logic                 odd_r;
   stop_bits_t           stops_r;
   logic                 perr_r;
   logic                 stop1_zero_r;

   logic [7:0] rx_data_r;
   logic       rx_valid_r, parity_err_r, frame_err_r, overrun_err_r;

   logic tick_s, latch_cfg_s, shift_en_s, par_en_s, stop1_en_s, complete_s, frame_err_s;

   uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_in),
      .q     (rx_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state and per-cycle sample strobes.
   always_comb begin
      state_nxt   = state_r;
      tick_s      = 1'b0;
      latch_cfg_s = 1'b0;
      shift_en_s  = 1'b0;
      par_en_s    = 1'b0;
      stop1_en_s  = 1'b0;
      complete_s  = 1'b0;
      frame_err_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!rx_s) state_nxt = ST_START;
            else       state_nxt = ST_IDLE;
         end
         ST_START: begin
            if (cnt_r == HALF_M1) begin
               tick_s = 1'b1;
               if (!rx_s) begin
                  state_nxt   = ST_DATA;
                  latch_cfg_s = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               state_nxt = ST_START;
            end
         end
         ST_DATA: begin
            if (cnt_r == FULL_M1) begin
               tick_s     = 1'b1;
               shift_en_s = 1'b1;
               if (bit_cnt_r == LAST_BIT) state_nxt = ST_PARITY;
               else                       state_nxt = ST_DATA;
            end else begin
               state_nxt = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (cnt_r == FULL_M1) begin
               tick_s    = 1'b1;
               par_en_s  = 1'b1;
               state_nxt = ST_STOP1;
            end else begin
               state_nxt = ST_PARITY;
            end
         end
         ST_STOP1: begin
            if (cnt_r == FULL_M1) begin
               tick_s = 1'b1;
               if (stops_r == STOP_TWO) begin
                  stop1_en_s = 1'b1;
                  state_nxt  = ST_STOP2;
               end else begin
                  complete_s  = 1'b1;
                  frame_err_s = ~rx_s;
                  state_nxt   = rx_s ? ST_IDLE : ST_BREAK_WAIT;
               end
            end else begin
               state_nxt = ST_STOP1;
            end
         end
         ST_STOP2: begin
            if (cnt_r == FULL_M1) begin
               tick_s      = 1'b1;
               complete_s  = 1'b1;
               frame_err_s = stop1_zero_r | ~rx_s;
               state_nxt   = rx_s ? ST_IDLE : ST_BREAK_WAIT;
            end else begin
               state_nxt = ST_STOP2;
            end
         end
         ST_BREAK_WAIT: begin
            if (rx_s) state_nxt = ST_IDLE;
            else      state_nxt = ST_BREAK_WAIT;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Baud counter restarts on every state change and after every bit sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if ((state_nxt != state_r) || tick_s ||
                   (state_r == ST_IDLE) || (state_r == ST_BREAK_WAIT)) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + 1'b1;
      end
   end

   // Frame datapath: shift register, latched configuration, per-frame error bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r    <= 3'd0;
         shift_r      <= '0;
         odd_r        <= 1'b0;
         stops_r      <= STOP_ONE;
         perr_r       <= 1'b0;
         stop1_zero_r <= 1'b0;
      end else begin
         if (latch_cfg_s) begin
            bit_cnt_r    <= 3'd0;
            odd_r        <= odd_parity;
            stops_r      <= stop_bits_t'(two_stop);
            stop1_zero_r <= 1'b0;
         end else if (shift_en_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
         end else if (par_en_s) begin
            perr_r <= (parity_of(shift_r) ^ rx_s) != odd_r;
         end else if (stop1_en_s) begin
            stop1_zero_r <= ~rx_s;
         end
      end
   end

   // Output buffer: a completion loads when empty or when drained this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_r     <= 8'h00;
         rx_valid_r    <= 1'b0;
         parity_err_r  <= 1'b0;
         frame_err_r   <= 1'b0;
         overrun_err_r <= 1'b0;
      end else if (complete_s && (!rx_valid_r || rx_ready)) begin
         rx_data_r     <= shift_r;
         rx_valid_r    <= 1'b1;
         parity_err_r  <= perr_r;
         frame_err_r   <= frame_err_s;
         overrun_err_r <= 1'b0;
      end else if (complete_s) begin
         overrun_err_r <= 1'b1;
      end else begin
         overrun_err_r <= 1'b0;
         if (rx_valid_r && rx_ready) rx_valid_r <= 1'b0;
      end
   end

   assign rx_data     = rx_data_r;
   assign rx_valid    = rx_valid_r;
   assign parity_err  = parity_err_r;
   assign frame_err   = frame_err_r;
   assign overrun_err = overrun_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// checked against a bit-level frame model.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int B = 416;
   localparam int LAT1 = 3 + B / 2 + 10 * B;
   localparam int LAT2 = LAT1 + B;

   typedef struct { logic [7:0] d; logic pe; logic fe; } rec_t;

   logic clk = 1'b0;
   logic rst_n, rx_in, odd_parity, two_stop, rx_ready;
   logic [7:0] rx_data;
   logic rx_valid, parity_err, frame_err, overrun_err;

   int n_checks = 0;
   int n_fail = 0;
   int pe = 0;
   int last_t0 = 0;
   int rise_cnt = 0, rise_edge = 0, ovr_cnt = 0, stab_err = 0;
   logic prev_valid = 1'b0, prev_ready = 1'b0;
   logic [9:0] prev_word = 10'd0;
   rec_t q[$];

   uart_rx #(.BAUD_DIVISOR(B)) dut (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .odd_parity(odd_parity),
      .two_stop(two_stop), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
      .overrun_err(overrun_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) pe <= pe + 1;

   // Observer: samples 1 time unit after each falling edge.
   always begin
      @(negedge clk);
      #1;
      if (rx_valid && !prev_valid) begin
         rise_cnt++;
         rise_edge = pe + 1;
      end
      if (rx_valid && rx_ready) q.push_back('{rx_data, parity_err, frame_err});
      if (overrun_err) ovr_cnt++;
      if (prev_valid && !prev_ready && rx_valid && ({rx_data, parity_err, frame_err} != prev_word))
         stab_err++;
      prev_valid = rx_valid;
      prev_ready = rx_ready;
      prev_word  = {rx_data, parity_err, frame_err};
   end

   function automatic int ones(input logic [7:0] d);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(d[i]);
      return n;
   endfunction

   // Correct parity bit for a byte under the given mode.
   function automatic logic model_pbit(input logic [7:0] d, input logic odd);
      return logic'((ones(d) + int'(odd)) % 2);
   endfunction

   function automatic logic model_perr(input logic [7:0] d, input logic pbit, input logic odd);
      return ((ones(d) + int'(pbit) + int'(odd)) % 2) == 1;
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1,
                             input logic s2, input int nstop, input bit pulse_ready,
                             input int abort_bit);
      logic bits [12];
      int nb;
      nb = 10 + nstop;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i + 1] = d[i];
      bits[9]  = pbit;
      bits[10] = s1;
      bits[11] = s2;
      @(negedge clk);
      last_t0 = pe + 1;
      for (int i = 0; i < nb; i++) begin
         rx_in = bits[i];
         for (int j = 0; j < B; j++) begin
            if (i == abort_bit && j == B / 2) begin
               rst_n = 1'b0;
               rx_in = 1'b1;
               return;
            end
            if (pulse_ready && i == 10) begin
               if (j == 2 + B / 2) rx_ready = 1'b1;
               else if (j == 3 + B / 2) rx_ready = 1'b0;
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #2;
      n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
      n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", parity_err); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
      n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun_err); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_even_one_stop();
      odd_parity = 1'b0; two_stop = 1'b0; rx_ready = 1'b1;
      q.delete();
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1, 1'b0, -1);
      repeat (4) @(negedge clk);
      n_checks++; if (q.size() !== 1) begin n_fail++; $display("FAIL a5_count: got %0d want 1", q.size()); end
      else begin
         n_checks++; if (q[0].d !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h want a5", q[0].d); end
         n_checks++; if (q[0].pe !== 1'b0 || q[0].fe !== 1'b0) begin n_fail++; $display("FAIL a5_flags: got %b%b want 00", q[0].pe, q[0].fe); end
      end
      n_checks++; if (rise_edge - last_t0 !== LAT1) begin n_fail++; $display("FAIL a5_latency: got %0d want %0d", rise_edge - last_t0, LAT1); end
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL a5_single_cycle: got %b want 0", rx_valid); end
   endtask

   task automatic test_odd_two_stop();
      odd_parity = 1'b1; two_stop = 1'b1; rx_ready = 1'b1;
      q.delete();
      send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 2, 1'b0, -1);
      repeat (4) @(negedge clk);
      n_checks++; if (q.size() !== 1) begin n_fail++; $display("FAIL 3c_count: got %0d want 1", q.size()); end
      else begin
         n_checks++; if (q[0].d !== 8'h3C) begin n_fail++; $display("FAIL 3c_data: got %h want 3c", q[0].d); end
         n_checks++; if (q[0].pe !== 1'b1 || q[0].fe !== 1'b0) begin n_fail++; $display("FAIL 3c_flags: got %b%b want 10", q[0].pe, q[0].fe); end
      end
      n_checks++; if (rise_edge - last_t0 !== LAT2) begin n_fail++; $display("FAIL 3c_latency: got %0d want %0d", rise_edge - last_t0, LAT2); end
   endtask

   task automatic test_frame_break();
      logic [7:0] d;
      int rc0;
      odd_parity = 1'b0; two_stop = 1'b0; rx_ready = 1'b1;
      d = 8'($urandom_range(0, 255));
      q.delete();
      rc0 = rise_cnt;
      send_frame(d, model_pbit(d, 1'b0), 1'b0, 1'b1, 1, 1'b0, -1);
      repeat (3 * B) @(negedge clk);
      n_checks++; if (rise_cnt - rc0 !== 1) begin n_fail++; $display("FAIL brk_frames_low: got %0d want 1", rise_cnt - rc0); end
      n_checks++; if (q.size() !== 1) begin n_fail++; $display("FAIL brk_count: got %0d want 1", q.size()); end
      else begin
         n_checks++; if (q[0].d !== d || q[0].pe !== 1'b0 || q[0].fe !== 1'b1)
            begin n_fail++; $display("FAIL brk_rec: got %h/%b/%b want %h/0/1", q[0].d, q[0].pe, q[0].fe, d); end
      end
      rx_in = 1'b1;
      repeat (B) @(negedge clk);
      n_checks++; if (rise_cnt - rc0 !== 1) begin n_fail++; $display("FAIL brk_frames_high: got %0d want 1", rise_cnt - rc0); end
      q.delete();
      send_frame(8'h55, model_pbit(8'h55, 1'b0), 1'b1, 1'b1, 1, 1'b0, -1);
      repeat (4) @(negedge clk);
      n_checks++; if (q.size() !== 1) begin n_fail++; $display("FAIL 55_count: got %0d want 1", q.size()); end
      else begin
         n_checks++; if (q[0].d !== 8'h55 || q[0].pe !== 1'b0 || q[0].fe !== 1'b0)
            begin n_fail++; $display("FAIL 55_rec: got %h/%b/%b want 55/0/0", q[0].d, q[0].pe, q[0].fe); end
      end
   endtask

   task automatic test_glitch();
      int rc0;
      rc0 = rise_cnt;
      @(negedge clk);
      rx_in = 1'b0;
      repeat (200) @(negedge clk);
      rx_in = 1'b1;
      repeat (2 * B) @(negedge clk);
      n_checks++; if (rise_cnt - rc0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d frames want 0", rise_cnt - rc0); end
      n_checks++; if (dut.state_r !== ST_IDLE) begin n_fail++; $display("FAIL glitch_state: got %0d want %0d", dut.state_r, ST_IDLE); end
   endtask

   task automatic test_overrun();
      int ovr0;
      odd_parity = 1'b0; two_stop = 1'b0; rx_ready = 1'b0;
      q.delete();
      ovr0 = ovr_cnt;
      stab_err = 0;
      send_frame(8'h11, model_pbit(8'h11, 1'b0), 1'b1, 1'b1, 1, 1'b0, -1);
      repeat (4) @(negedge clk);
      n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_first: got %b/%h want 1/11", rx_valid, rx_data); end
      send_frame(8'h22, model_pbit(8'h22, 1'b0), 1'b1, 1'b1, 1, 1'b0, -1);
      repeat (4) @(negedge clk);
      n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_keep: got %h want 11", rx_data); end
      n_checks++; if (ovr_cnt - ovr0 !== 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt - ovr0); end
      send_frame(8'h33, model_pbit(8'h33, 1'b0), 1'b1, 1'b1, 1, 1'b1, -1);
      repeat (4) @(negedge clk);
      n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h33) begin n_fail++; $display("FAIL ovr_coincide: got %b/%h want 1/33", rx_valid, rx_data); end
      n_checks++; if (ovr_cnt - ovr0 !== 1) begin n_fail++; $display("FAIL ovr_none: got %0d want 1", ovr_cnt - ovr0); end
      n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL ovr_stable: got %0d changes want 0", stab_err); end
      rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (q.size() !== 2) begin n_fail++; $display("FAIL ovr_xfers: got %0d want 2", q.size()); end
      else begin
         n_checks++; if (q[0].d !== 8'h11 || q[1].d !== 8'h33) begin n_fail++; $display("FAIL ovr_order: got %h,%h want 11,33", q[0].d, q[1].d); end
      end
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %b want 0", rx_valid); end
   endtask

   task automatic test_reset_mid_frame();
      odd_parity = 1'b0; two_stop = 1'b0; rx_ready = 1'b0;
      send_frame(8'hC3, model_pbit(8'hC3, 1'b0), 1'b1, 1'b1, 1, 1'b0, -1);
      repeat (4) @(negedge clk);
      n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", rx_valid); end
      send_frame(8'h77, model_pbit(8'h77, 1'b0), 1'b1, 1'b1, 1, 1'b0, 5);
      #2;
      n_checks++; if ({rx_data, rx_valid, parity_err, frame_err, overrun_err} !== 12'h000)
         begin n_fail++; $display("FAIL rst_mid_outputs: got %h/%b%b%b%b want 00/0000", rx_data, rx_valid, parity_err, frame_err, overrun_err); end
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * B) @(negedge clk);
      rx_ready = 1'b1;
      q.delete();
      send_frame(8'h81, model_pbit(8'h81, 1'b0), 1'b1, 1'b1, 1, 1'b0, -1);
      repeat (4) @(negedge clk);
      n_checks++; if (q.size() !== 1) begin n_fail++; $display("FAIL 81_count: got %0d want 1", q.size()); end
      else begin
         n_checks++; if (q[0].d !== 8'h81 || q[0].pe !== 1'b0 || q[0].fe !== 1'b0)
            begin n_fail++; $display("FAIL 81_rec: got %h/%b/%b want 81/0/0", q[0].d, q[0].pe, q[0].fe); end
      end
      n_checks++; if (rise_edge - last_t0 !== LAT1) begin n_fail++; $display("FAIL 81_latency: got %0d want %0d", rise_edge - last_t0, LAT1); end
   endtask

   task automatic test_back_to_back_random();
      logic [7:0] d;
      logic odd, two, pbit, s1, s2, exp_pe, exp_fe, last_stop;
      int gap;
      rx_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         d    = 8'($urandom_range(0, 255));
         odd  = 1'($urandom_range(0, 1));
         two  = 1'($urandom_range(0, 1));
         pbit = model_pbit(d, odd) ^ ($urandom_range(0, 2) == 0);
         s1   = ($urandom_range(0, 3) != 0);
         s2   = two ? ($urandom_range(0, 3) != 0) : 1'b1;
         exp_pe = model_perr(d, pbit, odd);
         exp_fe = !s1 || (two && !s2);
         last_stop = two ? s2 : s1;
         odd_parity = odd;
         two_stop   = two;
         q.delete();
         send_frame(d, pbit, s1, s2, two ? 2 : 1, 1'b0, -1);
         rx_in = 1'b1;
         n_checks++; if (q.size() !== 1) begin n_fail++; $display("FAIL rnd%0d_count: got %0d want 1", k, q.size()); end
         else begin
            n_checks++; if (q[0].d !== d || q[0].pe !== exp_pe || q[0].fe !== exp_fe)
               begin n_fail++; $display("FAIL rnd%0d_rec: got %h/%b/%b want %h/%b/%b", k, q[0].d, q[0].pe, q[0].fe, d, exp_pe, exp_fe); end
         end
         n_checks++; if (rise_edge - last_t0 !== (two ? LAT2 : LAT1))
            begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", k, rise_edge - last_t0, two ? LAT2 : LAT1); end
         gap = $urandom_range(0, 3) + (last_stop ? 0 : 4);
         repeat (gap) @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0; rx_in = 1'b1; rx_ready = 1'b1; odd_parity = 1'b0; two_stop = 1'b0;
      test_reset();
      test_even_one_stop();
      test_odd_two_stop();
      test_frame_break();
      test_glitch();
      test_overrun();
      test_reset_mid_frame();
      test_back_to_back_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
